// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard sequencer:
//   hz_state_t          - sequencer FSM state encoding (2 bits)
//   DEFAULT_MEM_TIMEOUT - default number of consecutive data-memory wait
//                         cycles tolerated before the sequencer faults
// -----------------------------------------------------------------------------
package hazard_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FAULT    = 2'd2
   } hz_state_t;

   localparam int DEFAULT_MEM_TIMEOUT = 64;

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for hazard performance statistics. It sticks at
// all-ones instead of wrapping.
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset (clears count)
//   inc      in  increment request for this cycle
//   count    out current count, W bits
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (inc && !(&count)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
// Pipeline hazard controller: resolves load-use stalls, taken-branch flushes
// and data-memory wait stalls, and faults after too many consecutive memory
// wait cycles. Control outputs are purely combinational on state and inputs.
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the three saturating
// performance counters; otherwise the counter outputs are tied to zero.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   IDEX_MemRead, IDEX_Rt     EX-stage load flag and destination register
//   RS, RT, ID_UsesRt         ID-stage source registers and rt-use flag
//   BranchTaken               EX-stage branch/jump resolved taken
//   MemReq, MemReady          MEM-stage access pending / completing
//   PCWrite .. EXMEMWrite     pipeline register write enables
//   HazardMux                 insert a bubble into ID/EX
//   IFIDFlush, IDEXFlush      squash wrong-path instructions
//   MemTimeout                sequencer is in FAULT
//   LuStallCnt, MemStallCnt,
//   FlushCnt                  performance counters (CNT_W bits)
//   dbg_state                 current FSM state, for observation
//
// Handshake: MemReq/MemReady is a valid/ready pair. An access completes in the
// cycle where MemReq and MemReady are both high; MemReq high with MemReady low
// is a wait cycle, and MemReq dropping while waiting also ends the wait.
// -----------------------------------------------------------------------------
module hazard_sequencer
   import hazard_pkg::*;
#(
   parameter int REG_W       = 5,
   parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             IDEX_MemRead,
   input  logic [REG_W-1:0] IDEX_Rt,
   input  logic [REG_W-1:0] RS,
   input  logic [REG_W-1:0] RT,
   input  logic             ID_UsesRt,
   input  logic             BranchTaken,
   input  logic             MemReq,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEXWrite,
   output logic             EXMEMWrite,
   output logic             HazardMux,
   output logic             IFIDFlush,
   output logic             IDEXFlush,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] LuStallCnt,
   output logic [CNT_W-1:0] MemStallCnt,
   output logic [CNT_W-1:0] FlushCnt,
   output logic [1:0]       dbg_state
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   hz_state_t         state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              mem_stall, lu_stall;

   assign mem_stall = MemReq & ~MemReady;
   // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
   assign lu_stall  = IDEX_MemRead & (IDEX_Rt != '0) &
                      ((IDEX_Rt == RS) | (ID_UsesRt & (IDEX_Rt == RT)));
   assign dbg_state = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // wait_cnt holds the number of consecutive stall cycles already seen,
   // including the RUN cycle in which the stall started.
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         ST_RUN: begin
            wait_nxt = '0;
            if (mem_stall) begin
               wait_nxt  = WAIT_W'(1);
               state_nxt = (MEM_TIMEOUT <= 1) ? ST_FAULT : ST_MEM_WAIT;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_stall) begin
               if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                  state_nxt = ST_FAULT;
               end else begin
                  wait_nxt = wait_cnt + WAIT_W'(1);
               end
            end else begin
               // MemReady or MemReq dropping both end the wait this cycle.
               state_nxt = ST_RUN;
               wait_nxt  = '0;
            end
         end
         ST_FAULT: begin
            state_nxt = ST_FAULT;
         end
         default: begin
            state_nxt = ST_RUN;
            wait_nxt  = '0;
         end
      endcase
   end

   // Priority: FAULT > mem_stall > BranchTaken > lu_stall. While reset is
   // asserted the pipeline sees the free-running defaults.
   always_comb begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IDEXWrite  = 1'b1;
      EXMEMWrite = 1'b1;
      HazardMux  = 1'b0;
      IFIDFlush  = 1'b0;
      IDEXFlush  = 1'b0;
      MemTimeout = 1'b0;
      if (!reset_n) begin
         MemTimeout = 1'b0;
      end else if (state == ST_FAULT) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IDEXWrite  = 1'b0;
         EXMEMWrite = 1'b0;
         MemTimeout = 1'b1;
      end else if (mem_stall) begin
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IDEXWrite  = 1'b0;
         EXMEMWrite = 1'b0;
      end else if (BranchTaken) begin
         IFIDFlush = 1'b1;
         IDEXFlush = 1'b1;
      end else if (lu_stall) begin
         PCWrite   = 1'b0;
         IFIDWrite = 1'b0;
         HazardMux = 1'b1;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic lu_inc, mem_inc, fl_inc;

   // Classify the cycle from the decoded outputs so the counters track exactly
   // what the pipeline was told to do.
   assign lu_inc  = HazardMux;
   assign mem_inc = ~EXMEMWrite & ~MemTimeout;
   assign fl_inc  = IFIDFlush;

   sat_counter #(.W(CNT_W)) u_lu_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (lu_inc),
      .count   (LuStallCnt)
   );

   sat_counter #(.W(CNT_W)) u_mem_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (mem_inc),
      .count   (MemStallCnt)
   );

   sat_counter #(.W(CNT_W)) u_fl_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (fl_inc),
      .count   (FlushCnt)
   );
`else
   assign LuStallCnt  = '0;
   assign MemStallCnt = '0;
   assign FlushCnt    = '0;
`endif

endmodule
